// File: rtl/ex_alu_unit.sv
// Execute-stage ALU with valid/ready handshakes on both sides and a one-bit-per-cycle shifter.
// Define EX_ALU_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module ex_alu_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  alu_control,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [3:0]  flags,
  output logic [1:0]  dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // the upstream holds its operation until that edge, and the unit holds result/flags
  // with out_valid high until that edge on the downstream side.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;
  localparam logic [3:0] OP_OR   = 4'b1100;
  localparam logic [3:0] OP_AND  = 4'b1110;
  localparam logic [3:0] OP_SRA  = 4'b1111;

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] work_q, work_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic [3:0]  flags_q, flags_d;

  logic        accept;
  logic        iter_start;
  logic [31:0] shift_step;
  logic [35:0] calc;

  // Returns {N, Z, C, V, result}; unlisted codes fall through to ADD.
  function automatic logic [35:0] alu_calc(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [32:0] sum;
    logic [31:0] r;
    logic        c;
    logic        v;
    sum = {1'b0, a} + {1'b0, b};
    r   = sum[31:0];
    c   = sum[32];
    v   = (a[31] == b[31]) && (r[31] != a[31]);
    case (op)
      OP_SUB: begin
        sum = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r   = sum[31:0];
        c   = sum[32];
        v   = (a[31] != b[31]) && (r[31] != a[31]);
      end
`ifdef EX_ALU_FAST_SHIFT_EN
      OP_SLL:  begin r = a << b[4:0];                       c = 1'b0; v = 1'b0; end
      OP_SRL:  begin r = a >> b[4:0];                       c = 1'b0; v = 1'b0; end
      OP_SRA:  begin r = $unsigned($signed(a) >>> b[4:0]);  c = 1'b0; v = 1'b0; end
`else
      // Only reached with a zero shift amount; non-zero amounts go through SHIFT.
      OP_SLL, OP_SRL, OP_SRA: begin r = a; c = 1'b0; v = 1'b0; end
`endif
      OP_SLT:  begin r = {31'd0, $signed(a) < $signed(b)}; c = 1'b0; v = 1'b0; end
      OP_SLTU: begin r = {31'd0, a < b};                   c = 1'b0; v = 1'b0; end
      OP_XOR:  begin r = a ^ b;                            c = 1'b0; v = 1'b0; end
      OP_OR:   begin r = a | b;                            c = 1'b0; v = 1'b0; end
      OP_AND:  begin r = a & b;                            c = 1'b0; v = 1'b0; end
      default: ;
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

`ifdef EX_ALU_FAST_SHIFT_EN
  assign iter_start = 1'b0;
`else
  assign iter_start = ((alu_control == OP_SLL) || (alu_control == OP_SRL) ||
                       (alu_control == OP_SRA)) && (src_b[4:0] != 5'd0);
`endif

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign calc      = alu_calc(alu_control, src_a, src_b);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign flags     = flags_q;
  assign dbg_state = state_q;

  always_comb begin
    case (op_q)
      OP_SLL:  shift_step = {work_q[30:0], 1'b0};
      OP_SRL:  shift_step = {1'b0, work_q[31:1]};
      default: shift_step = {work_q[31], work_q[31:1]};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      SHIFT: begin
        work_d = shift_step;
        cnt_d  = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d  = DONE;
          result_d = shift_step;
          flags_d  = {shift_step[31], (shift_step == 32'd0), 2'b00};
        end
      end
      DONE: begin
        if (out_ready && !in_valid) state_d = IDLE;
      end
      default: ;
    endcase
    // A new operation can be taken in IDLE or while the old result drains (no bubble).
    if (accept) begin
      op_d = alu_control;
      if (iter_start) begin
        state_d = SHIFT;
        work_d  = src_a;
        cnt_d   = src_b[4:0];
      end else begin
        state_d  = DONE;
        result_d = calc[31:0];
        flags_d  = calc[35:32];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      work_q   <= 32'd0;
      cnt_q    <= 5'd0;
      result_q <= 32'd0;
      flags_q  <= 4'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

endmodule

// File: tb/tb_ex_alu_unit.sv
// Directed testbench for ex_alu_unit: hand-computed results, flags, latency and handshake checks.
module tb_ex_alu_unit;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_control;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;
  logic [1:0]  dbg_state;

  int n_assert = 0;
  int n_fail   = 0;
  int lat;
  int busy;
  int stale;

`ifdef EX_ALU_FAST_SHIFT_EN
  localparam int FAST = 1;
`else
  localparam int FAST = 0;
`endif

  ex_alu_unit dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .flags       (flags),
    .dbg_state   (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive an op mid-cycle, confirm it is accepted, and return 1ns into cycle T+1.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid    = 1'b1;
    alu_control = op;
    src_a       = a;
    src_b       = b;
    #1;
    chk("send_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count cycles from T+1 until out_valid, also counting cycles with in_ready low.
  task automatic wait_out(output int l, output int b);
    l = 1;
    b = 0;
    while (!out_valid && l < 60) begin
      if (!in_ready) b++;
      @(posedge clk);
      #1;
      l++;
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r,
                        input logic [3:0] exp_f, input int exp_lat);
    send(op, a, b);
    wait_out(lat, busy);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, result, exp_r);
    chk({tag, "_flg"}, {28'd0, flags}, {28'd0, exp_f});
  endtask

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    alu_control = 4'd0;
    src_a       = 32'd0;
    src_b       = 32'd0;
    out_ready   = 1'b1;
    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {28'd0, flags}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Arithmetic and logic, back-to-back with out_ready held high
    run_op("add_ovf",  4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001, 1);
    run_op("add_cry",  4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110, 1);
    run_op("sub_eq",   4'b0010, 32'd5,         32'd5,         32'h0000_0000, 4'b0110, 1);
    run_op("sub_neg",  4'b0010, 32'd3,         32'd5,         32'hFFFF_FFFE, 4'b1000, 1);
    run_op("sub_ovf",  4'b0010, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 4'b0011, 1);
    run_op("sltu",     4'b1011, 32'd1,         32'hFFFF_FFFF, 32'd1,         4'b0000, 1);
    run_op("slt",      4'b0110, 32'd1,         32'hFFFF_FFFF, 32'd0,         4'b0100, 1);
    run_op("xor",      4'b1010, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 4'b0000, 1);
    run_op("or",       4'b1100, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 4'b0000, 1);
    run_op("and",      4'b1110, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 4'b0000, 1);
    run_op("fallback", 4'b0101, 32'd3,         32'd4,         32'd7,         4'b0000, 1);

    // Shifts: zero amount, short, long, arithmetic
    run_op("sll0", 4'b0100, 32'h0000_0001, 32'h0000_0020, 32'h0000_0001, 4'b0000, 1);
    run_op("sll1", 4'b0100, 32'h0000_0003, 32'd1,         32'h0000_0006, 4'b0000, FAST ? 1 : 2);
    run_op("sra4", 4'b1111, 32'h8000_0000, 32'd4,         32'hF800_0000, 4'b1000, FAST ? 1 : 5);
    chk("sra4_busy", busy, FAST ? 0 : 4);
    run_op("srl31", 4'b1000, 32'h8000_0000, 32'd31,       32'h0000_0001, 4'b0000, FAST ? 1 : 32);

    // Hold under backpressure, then back-to-back accept as the result drains
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    run_op("hold", 4'b1110, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000, 4'b0000, 1);
    in_valid    = 1'b1;
    alu_control = 4'b0000;
    src_a       = 32'd100;
    src_b       = 32'd1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_res", result, 32'h0F0F_0000);
      chk("hold_flg", {28'd0, flags}, 32'd0);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    run_op("b2b", 4'b0000, 32'd10, 32'd20, 32'd30, 4'b0000, 1);

    // Reset in the middle of a long shift
    @(posedge clk);
    #1;
    send(4'b0100, 32'h0000_0001, 32'd20);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("mid_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_state", {30'd0, dbg_state}, FAST ? 32'd0 : 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_flags", {28'd0, flags}, 32'd0);
    chk("arst_state", {30'd0, dbg_state}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
    stale = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (out_valid) stale++;
    end
    chk("no_stale", stale, 0);
    chk("rel_result", result, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
